req_ack_monitor: RTL and testbench
==================================

REQ_ACK_MONITOR -- requirements
Module: req_ack_monitor

Interface
REQ-001 Parameter DW, default 32, width of bus_data and last_data.
REQ-002 Parameter TIMEOUT, default 8, max legal req-to-ack latency in cycles; legal range 1..255.
REQ-003 Parameter CNTW, default 16, width of txn_count.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 bus_req  input  1  transaction request, single-cycle pulse.
REQ-007 bus_ack  input  1  transaction acknowledge, single-cycle pulse.
REQ-008 bus_data  input  DW  payload, valid in the cycle bus_req=1.
REQ-009 clear_err  input  1  synchronous clear of sticky error flags.
REQ-010 busy  output  1  1 while a transaction is outstanding (state WAIT).
REQ-011 done  output  1  one-cycle pulse, registered, after each completed transaction.
REQ-012 last_data  output  DW  bus_data captured at the most recent accepted request.
REQ-013 last_latency  output  8  latency of the most recent completed transaction.
REQ-014 txn_count  output  CNTW  number of completed transactions, saturating.
REQ-015 err_overlap, err_spurious, err_timeout  output  1 each  sticky protocol error flags.
REQ-016 err_pulse  output  1  one-cycle pulse, registered, in the cycle after any error is detected.

Function
REQ-017 States: IDLE (no outstanding request) and WAIT (request outstanding); latency counter lat, 8 bits.
REQ-018 IDLE, bus_req=1: capture bus_data into last_data, lat<=1, go WAIT.
REQ-019 IDLE, bus_ack=1: set err_spurious, pulse err_pulse; if bus_req also 1, REQ-018 still applies.
REQ-020 WAIT, bus_ack=1: last_latency<=lat, txn_count increments, done pulses next cycle, go IDLE.
REQ-021 WAIT, bus_ack=1 and bus_req=1 same edge: complete per REQ-020, then accept new request per REQ-018 (stay WAIT, lat<=1); no error.
REQ-022 WAIT, bus_req=1, bus_ack=0: set err_overlap, ignore the request (last_data, lat unaffected except REQ-023).
REQ-023 WAIT, bus_ack=0, lat<TIMEOUT: lat increments by 1.
REQ-024 WAIT, bus_ack=0, lat==TIMEOUT: set err_timeout, go IDLE; txn_count and last_latency unchanged.
REQ-025 Timeout edge with bus_req=1: timeout flagged and the request accepted (WAIT, lat<=1, data captured); err_overlap not set.
REQ-026 Ack with lat==TIMEOUT is legal and completes with last_latency=TIMEOUT.
REQ-027 txn_count saturates at all-ones; no wrap.
REQ-028 clear_err=1 clears all three sticky flags; an error detected on the same edge wins (flag set).
REQ-029 err_pulse asserted one cycle for any edge with one or more errors; multiple simultaneous errors give one pulse.
REQ-030 busy is the registered state (1 iff WAIT); no combinational path from inputs to any output.

Reset
REQ-031 reset=1 forces immediately: state IDLE, lat=0, busy=0, done=0, err_pulse=0, last_data=0, last_latency=0, txn_count=0, all error flags 0.
REQ-032 Reset mid-transaction discards the outstanding request; no done, no error reported.
REQ-033 First edge after reset deasserts behaves as IDLE.

Verification
REQ-034 req pulse with bus_data=32'hfeed, ack 2 cycles later -> last_data=32'hfeed, last_latency=2, txn_count=1, done one pulse, no errors.
REQ-035 req, no ack for 8 cycles (TIMEOUT=8) -> err_timeout=1 at 8th edge, busy=0, txn_count=0; ack 1 cycle later -> err_spurious=1.
REQ-036 req then req again next cycle, ack after -> err_overlap=1, last_data holds first payload, txn_count=1, last_latency=2.
REQ-037 ack coincident with new req, then ack 3 cycles later -> txn_count=2, last_latency 1 then 3, busy stays 1 between, no errors.
REQ-038 set err_spurious, assert clear_err alone -> flag 0; clear_err with simultaneous spurious ack -> flag stays 1, err_pulse pulses.
REQ-039 reset asserted while busy=1 mid-wait -> all outputs zero immediately; later normal transaction completes with txn_count=1.

Source files
------------

// File: rtl/req_ack_monitor.sv
// Request/acknowledge protocol monitor: tracks one outstanding transaction, measures
// its latency, counts completions and raises sticky protocol error flags.
module req_ack_monitor #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 8,
  parameter int CNTW    = 16
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_bus_req,
  input  logic            i_bus_ack,
  input  logic [DW-1:0]   i_bus_data,
  input  logic            i_clear_err,
  output logic            o_busy,
  output logic            o_done,
  output logic [DW-1:0]   o_last_data,
  output logic [7:0]      o_last_latency,
  output logic [CNTW-1:0] o_txn_count,
  output logic            o_err_overlap,
  output logic            o_err_spurious,
  output logic            o_err_timeout,
  output logic            o_err_pulse
);

  // state | meaning
  // IDLE  | no request outstanding
  // WAIT  | request accepted, waiting for ack; r_lat counts cycles since the request
  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [7:0] LP_TMO = 8'(TIMEOUT);

  state_t            r_state;
  logic [7:0]        r_lat;
  logic [DW-1:0]     r_last_data;
  logic [7:0]        r_last_latency;
  logic [CNTW-1:0]   r_txn_count;
  logic              r_done;
  logic              r_err_overlap;
  logic              r_err_spurious;
  logic              r_err_timeout;
  logic              r_err_pulse;

  logic w_wait;
  logic w_lat_end;
  logic w_complete;
  logic w_timeout;
  logic w_overlap;
  logic w_spurious;
  logic w_accept;

  always_comb begin
    w_wait     = (r_state == S_WAIT);
    w_lat_end  = (r_lat == LP_TMO);
    w_complete = w_wait && i_bus_ack;
    w_timeout  = w_wait && !i_bus_ack && w_lat_end;
    // A request landing on the timeout edge is accepted, not an overlap.
    w_overlap  = w_wait && !i_bus_ack && !w_lat_end && i_bus_req;
    w_spurious = !w_wait && i_bus_ack;
    w_accept   = i_bus_req && (!w_wait || i_bus_ack || w_lat_end);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_lat          <= '0;
      r_last_data    <= '0;
      r_last_latency <= '0;
      r_txn_count    <= '0;
      r_done         <= 1'b0;
      r_err_overlap  <= 1'b0;
      r_err_spurious <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_err_pulse    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_state     <= S_WAIT;
        r_lat       <= 8'd1;
        r_last_data <= i_bus_data;
      end else if (w_complete || w_timeout) begin
        r_state <= S_IDLE;
        r_lat   <= '0;
      end else if (w_wait && !w_lat_end) begin
        r_lat <= r_lat + 8'd1;
      end

      r_done <= w_complete;
      if (w_complete) begin
        r_last_latency <= r_lat;
        if (r_txn_count != '1) r_txn_count <= r_txn_count + 1'b1;
      end

      r_err_overlap  <= (r_err_overlap  && !i_clear_err) || w_overlap;
      r_err_spurious <= (r_err_spurious && !i_clear_err) || w_spurious;
      r_err_timeout  <= (r_err_timeout  && !i_clear_err) || w_timeout;
      r_err_pulse    <= w_overlap || w_spurious || w_timeout;
    end
  end

  assign o_busy         = (r_state == S_WAIT);
  assign o_done         = r_done;
  assign o_last_data    = r_last_data;
  assign o_last_latency = r_last_latency;
  assign o_txn_count    = r_txn_count;
  assign o_err_overlap  = r_err_overlap;
  assign o_err_spurious = r_err_spurious;
  assign o_err_timeout  = r_err_timeout;
  assign o_err_pulse    = r_err_pulse;

endmodule

// File: tb/tb_req_ack_monitor.sv
// Directed self-checking bench for req_ack_monitor (TIMEOUT=8, narrow counter to reach saturation).
module tb_req_ack_monitor;
  localparam int DW = 32;
  localparam int TIMEOUT = 8;
  localparam int CNTW = 3;

  logic            i_clk = 1'b0;
  logic            i_reset = 1'b1;
  logic            i_bus_req = 1'b0;
  logic            i_bus_ack = 1'b0;
  logic [DW-1:0]   i_bus_data = '0;
  logic            i_clear_err = 1'b0;
  logic            o_busy, o_done, o_err_overlap, o_err_spurious, o_err_timeout, o_err_pulse;
  logic [DW-1:0]   o_last_data;
  logic [7:0]      o_last_latency;
  logic [CNTW-1:0] o_txn_count;

  int n_tests = 0;
  int n_fail = 0;

  req_ack_monitor #(.DW(DW), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_bus_req(i_bus_req), .i_bus_ack(i_bus_ack),
    .i_bus_data(i_bus_data), .i_clear_err(i_clear_err), .o_busy(o_busy), .o_done(o_done),
    .o_last_data(o_last_data), .o_last_latency(o_last_latency), .o_txn_count(o_txn_count),
    .o_err_overlap(o_err_overlap), .o_err_spurious(o_err_spurious),
    .o_err_timeout(o_err_timeout), .o_err_pulse(o_err_pulse)
  );

  always #5 i_clk = ~i_clk;

  // Drive one cycle of inputs, let the edge happen, then sample 1 time unit later.
  task automatic step(input logic req, input logic ack, input logic clr, input logic [DW-1:0] d);
    i_bus_req = req; i_bus_ack = ack; i_clear_err = clr; i_bus_data = d;
    @(posedge i_clk); #1;
    i_bus_req = 1'b0; i_bus_ack = 1'b0; i_clear_err = 1'b0; i_bus_data = '0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    #2;
    n_tests++;
    if ({o_busy, o_done, o_err_pulse, o_err_overlap, o_err_spurious, o_err_timeout} !== 6'b0) begin
      $display("FAIL reset_flags: got %b expected 000000",
               {o_busy, o_done, o_err_pulse, o_err_overlap, o_err_spurious, o_err_timeout});
      n_fail++;
    end
    n_tests++;
    if ({o_last_data, o_last_latency, o_txn_count} !== '0) begin
      $display("FAIL reset_data: got data=%h lat=%0d cnt=%0d expected zeros",
               o_last_data, o_last_latency, o_txn_count);
      n_fail++;
    end
    @(posedge i_clk); #1;
    i_reset = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    step(1, 0, 0, 32'hfeed);
    n_tests++;
    if (o_busy !== 1'b1) begin $display("FAIL basic_busy: got %b expected 1", o_busy); n_fail++; end
    step(0, 0, 0, '0);
    step(0, 1, 0, '0);
    n_tests++;
    if ({o_busy, o_done} !== 2'b01) begin
      $display("FAIL basic_done: got busy,done=%b expected 01", {o_busy, o_done}); n_fail++;
    end
    n_tests++;
    if (o_last_data !== 32'hfeed || o_last_latency !== 8'd2 || o_txn_count !== 3'd1) begin
      $display("FAIL basic_result: got data=%h lat=%0d cnt=%0d expected feed 2 1",
               o_last_data, o_last_latency, o_txn_count); n_fail++;
    end
    step(0, 0, 0, '0);
    n_tests++;
    if ({o_done, o_err_pulse, o_err_overlap, o_err_spurious, o_err_timeout} !== 5'b0) begin
      $display("FAIL basic_after: got done,errs=%b expected 00000",
               {o_done, o_err_pulse, o_err_overlap, o_err_spurious, o_err_timeout}); n_fail++;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    step(1, 0, 0, 32'ha1);
    for (int i = 0; i < 7; i++) step(0, 0, 0, '0);
    n_tests++;
    if ({o_busy, o_err_timeout} !== 2'b10) begin
      $display("FAIL tmo_before: got busy,tmo=%b expected 10", {o_busy, o_err_timeout}); n_fail++;
    end
    step(0, 0, 0, '0);
    n_tests++;
    if ({o_busy, o_err_timeout, o_err_pulse, o_txn_count} !== {3'b011, 3'd0}) begin
      $display("FAIL tmo_edge: got busy,tmo,pulse=%b cnt=%0d expected 011 0",
               {o_busy, o_err_timeout, o_err_pulse}, o_txn_count); n_fail++;
    end
    step(0, 1, 0, '0);
    n_tests++;
    if ({o_err_spurious, o_err_pulse, o_txn_count} !== {2'b11, 3'd0}) begin
      $display("FAIL tmo_late_ack: got spur,pulse=%b cnt=%0d expected 11 0",
               {o_err_spurious, o_err_pulse}, o_txn_count); n_fail++;
    end
    step(0, 0, 1, '0);
    n_tests++;
    if ({o_err_overlap, o_err_spurious, o_err_timeout} !== 3'b000) begin
      $display("FAIL tmo_clear: got flags=%b expected 000",
               {o_err_overlap, o_err_spurious, o_err_timeout}); n_fail++;
    end
  endtask

  task automatic test_overlap();
    do_reset();
    step(1, 0, 0, 32'h11);
    step(1, 0, 0, 32'h22);
    n_tests++;
    if ({o_err_overlap, o_err_pulse, o_busy} !== 3'b111) begin
      $display("FAIL ovl_flag: got ovl,pulse,busy=%b expected 111",
               {o_err_overlap, o_err_pulse, o_busy}); n_fail++;
    end
    step(0, 1, 0, '0);
    n_tests++;
    if (o_last_data !== 32'h11 || o_last_latency !== 8'd2 || o_txn_count !== 3'd1) begin
      $display("FAIL ovl_result: got data=%h lat=%0d cnt=%0d expected 11 2 1",
               o_last_data, o_last_latency, o_txn_count); n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1, 0, 0, 32'h33);
    step(1, 1, 0, 32'h44);
    n_tests++;
    if (o_busy !== 1'b1 || o_last_latency !== 8'd1 || o_txn_count !== 3'd1 || o_last_data !== 32'h44) begin
      $display("FAIL b2b_first: got busy=%b lat=%0d cnt=%0d data=%h expected 1 1 1 44",
               o_busy, o_last_latency, o_txn_count, o_last_data); n_fail++;
    end
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    n_tests++;
    if (o_busy !== 1'b1) begin $display("FAIL b2b_busy: got %b expected 1", o_busy); n_fail++; end
    step(0, 1, 0, '0);
    n_tests++;
    if (o_busy !== 1'b0 || o_last_latency !== 8'd3 || o_txn_count !== 3'd2) begin
      $display("FAIL b2b_second: got busy=%b lat=%0d cnt=%0d expected 0 3 2",
               o_busy, o_last_latency, o_txn_count); n_fail++;
    end
    n_tests++;
    if ({o_err_overlap, o_err_spurious, o_err_timeout} !== 3'b000) begin
      $display("FAIL b2b_errs: got flags=%b expected 000",
               {o_err_overlap, o_err_spurious, o_err_timeout}); n_fail++;
    end
  endtask

  task automatic test_clear();
    do_reset();
    step(0, 1, 0, '0);
    n_tests++;
    if ({o_err_spurious, o_err_pulse} !== 2'b11) begin
      $display("FAIL clr_set: got spur,pulse=%b expected 11", {o_err_spurious, o_err_pulse}); n_fail++;
    end
    step(0, 0, 0, '0);
    n_tests++;
    if ({o_err_spurious, o_err_pulse} !== 2'b10) begin
      $display("FAIL clr_sticky: got spur,pulse=%b expected 10", {o_err_spurious, o_err_pulse}); n_fail++;
    end
    step(0, 0, 1, '0);
    n_tests++;
    if (o_err_spurious !== 1'b0) begin
      $display("FAIL clr_alone: got %b expected 0", o_err_spurious); n_fail++;
    end
    step(0, 1, 1, '0);
    n_tests++;
    if ({o_err_spurious, o_err_pulse} !== 2'b11) begin
      $display("FAIL clr_collide: got spur,pulse=%b expected 11", {o_err_spurious, o_err_pulse}); n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1, 0, 0, 32'h77);
    step(0, 0, 0, '0);
    #2 i_reset = 1'b1;
    #1;
    n_tests++;
    if ({o_busy, o_done, o_err_pulse, o_err_overlap, o_err_spurious, o_err_timeout} !== 6'b0 ||
        o_last_data !== '0) begin
      $display("FAIL rst_mid: got busy..tmo=%b data=%h expected 000000 0",
               {o_busy, o_done, o_err_pulse, o_err_overlap, o_err_spurious, o_err_timeout}, o_last_data);
      n_fail++;
    end
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    step(1, 0, 0, 32'h88);
    step(0, 1, 0, '0);
    n_tests++;
    if (o_txn_count !== 3'd1 || o_last_latency !== 8'd1 || o_last_data !== 32'h88 || o_done !== 1'b1) begin
      $display("FAIL rst_after: got cnt=%0d lat=%0d data=%h done=%b expected 1 1 88 1",
               o_txn_count, o_last_latency, o_last_data, o_done); n_fail++;
    end
  endtask

  task automatic test_timeout_edges();
    do_reset();
    step(1, 0, 0, 32'h5);
    for (int i = 0; i < 7; i++) step(0, 0, 0, '0);
    step(0, 1, 0, '0);
    n_tests++;
    if (o_last_latency !== 8'd8 || o_err_timeout !== 1'b0 || o_txn_count !== 3'd1) begin
      $display("FAIL ack_at_tmo: got lat=%0d tmo=%b cnt=%0d expected 8 0 1",
               o_last_latency, o_err_timeout, o_txn_count); n_fail++;
    end
    step(1, 0, 0, 32'h55);
    for (int i = 0; i < 7; i++) step(0, 0, 0, '0);
    step(1, 0, 0, 32'h66);
    n_tests++;
    if ({o_err_timeout, o_err_overlap, o_busy, o_err_pulse} !== 4'b1011 || o_last_data !== 32'h66) begin
      $display("FAIL tmo_req: got tmo,ovl,busy,pulse=%b data=%h expected 1011 66",
               {o_err_timeout, o_err_overlap, o_busy, o_err_pulse}, o_last_data); n_fail++;
    end
    step(0, 1, 0, '0);
    n_tests++;
    if (o_last_latency !== 8'd1 || o_txn_count !== 3'd2) begin
      $display("FAIL tmo_req_ack: got lat=%0d cnt=%0d expected 1 2", o_last_latency, o_txn_count);
      n_fail++;
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1, 0, 0, DW'(i));
      step(0, 1, 0, '0);
    end
    n_tests++;
    if (o_txn_count !== 3'd7) begin
      $display("FAIL saturate: got cnt=%0d expected 7", o_txn_count); n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_overlap();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    test_timeout_edges();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
